// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 16-channel mux scan controller.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request/status and mux select/sample signals of the scan controller.
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic              start;
  logic              abort;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] data;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, mux_out,
    input  sel, data, busy, done
  );

  modport slave (
    input  start, abort, mux_out,
    output sel, data, busy, done
  );

endinterface

// File: rtl/mux16.sv
// 16:1 single-bit mux built from two 8:1 muxes; sel[3] picks the upper bank.
module mux16 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        y
);

  logic y_lo;
  logic y_hi;

  mux8 u_lo (.in(in[7:0]),  .sel(sel[2:0]), .y(y_lo));
  mux8 u_hi (.in(in[15:8]), .sel(sel[2:0]), .y(y_hi));

  assign y = sel[3] ? y_hi : y_lo;

endmodule

// File: rtl/mux8.sv
// 8:1 single-bit mux, building block of the existing 16:1 analog-select mux.
module mux8 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = in[sel];

endmodule

// File: rtl/settle_cnt.sv
// Settle timer: counts up while enabled, flags the terminal count and wraps to 0.
module settle_cnt #(
  parameter int unsigned    W      = 4,
  parameter logic [W-1:0]   TC_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 16:1 mux through all channels, holding each for SETTLE cycles and
// capturing the mux output into data[sel] at the end of each settle window.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; sel parked at 0
// ST_SCAN | settling/sampling channel sel; busy high
// ST_DONE | one-cycle completion pulse; sel back at 0
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_TC = 4'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              busy_q, done_q;
  logic              tc;
  logic              cnt_clr;
  logic              cnt_en;

  assign cnt_en  = (state_q == ST_SCAN);
  assign cnt_clr = (state_q != ST_SCAN) || bus.abort;

  settle_cnt #(
    .W      (4),
    .TC_VAL (SETTLE_TC)
  ) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // abort on a sampling edge wins: that channel is not captured
        if (bus.abort) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (tc) begin
          data_d[sel_q] = bus.mux_out;
          if (sel_q == SEL_W'(NUM_CH - 1)) begin
            state_d = ST_DONE;
            sel_d   = '0;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      busy_q  <= (state_d == ST_SCAN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.sel  = sel_q;
  assign bus.data = data_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: two controllers (SETTLE=2 and SETTLE=1), each on a 16:1 mux.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [1:0]       start_d;
  logic [1:0]       abort_d;
  logic [1:0]       rstn_d;
  logic [1:0][15:0] min_d;

  logic [1:0][3:0]  sel_w;
  logic [1:0][15:0] data_w;
  logic [1:0]       busy_w;
  logic [1:0]       done_w;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] model[2];

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int S = (g == 0) ? 2 : 1;
    mux_scan_ctrl_if bus();
    assign bus.start = start_d[g];
    assign bus.abort = abort_d[g];
    mux16 u_mux (.in(min_d[g]), .sel(bus.sel), .y(bus.mux_out));
    mux_scan_ctrl #(.SETTLE(S)) u_dut (.clk(clk), .rst_n(rstn_d[g]), .bus(bus));
    assign sel_w[g]  = bus.sel;
    assign data_w[g] = bus.data;
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
  end

  function automatic int settle(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // done monitor: every pulse must match the oldest outstanding scan
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_w[d] === 1'b1) begin
        exp_t e;
        int   have;
        have = (d == 0) ? q0.size() : q1.size();
        chk("done_expected", (have > 0) ? 32'd1 : 32'd0, 32'd1);
        if (have > 0) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("scan_data", 32'(data_w[d]), 32'(e.data));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // mode: 0 plain, 1 abort at edge E+at, 2 reset at edge E+at, 3 start re-pulsed at k==at
  task automatic run_scan(input int d, input logic [15:0] in, input int mode, input int at);
    int   s;
    int   e0;
    int   ncap;
    exp_t e;
    s = settle(d);
    @(negedge clk);
    min_d[d]   = in;
    start_d[d] = 1'b1;
    abort_d[d] = 1'b0;
    rstn_d[d]  = 1'b1;
    e0 = cyc + 1;
    if (mode == 0 || mode == 3) begin
      e.data = in;
      e.cyc  = e0 + 16 * s;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    for (int k = 0; k < 16 * s; k++) begin
      @(negedge clk);
      start_d[d] = 1'b0;
      chk("busy_scan", 32'(busy_w[d]), 32'd1);
      chk("sel_step", 32'(sel_w[d]), 32'(k / s));
      if (mode == 3 && k == at) start_d[d] = 1'b1;
      if ((mode == 1 || mode == 2) && k + 1 == at) begin
        if (mode == 1) abort_d[d] = 1'b1;
        else           rstn_d[d]  = 1'b0;
        @(negedge clk);
        abort_d[d] = 1'b0;
        rstn_d[d]  = 1'b1;
        if (mode == 1) begin
          ncap = (at - 1) / s;
          for (int j = 0; j < ncap; j++) model[d][j] = in[j];
        end else begin
          model[d] = 16'h0000;
        end
        chk("cut_busy", 32'(busy_w[d]), 32'd0);
        chk("cut_sel", 32'(sel_w[d]), 32'd0);
        chk("cut_done", 32'(done_w[d]), 32'd0);
        chk("cut_data", 32'(data_w[d]), 32'(model[d]));
        return;
      end
    end
    @(negedge clk);
    start_d[d] = 1'b0;
    chk("done_busy", 32'(busy_w[d]), 32'd0);
    chk("done_sel", 32'(sel_w[d]), 32'd0);
    if (mode == 3) start_d[d] = 1'b1;
    model[d] = in;
    @(negedge clk);
    start_d[d] = 1'b0;
    chk("idle_busy", 32'(busy_w[d]), 32'd0);
    chk("idle_done", 32'(done_w[d]), 32'd0);
    chk("idle_data", 32'(data_w[d]), 32'(model[d]));
  endtask

  task automatic idle_abort(input int d);
    @(negedge clk);
    start_d[d] = 1'b1;
    abort_d[d] = 1'b1;
    @(negedge clk);
    start_d[d] = 1'b0;
    abort_d[d] = 1'b0;
    chk("ia_busy", 32'(busy_w[d]), 32'd0);
    chk("ia_sel", 32'(sel_w[d]), 32'd0);
    @(negedge clk);
    chk("ia_busy2", 32'(busy_w[d]), 32'd0);
    chk("ia_data", 32'(data_w[d]), 32'(model[d]));
  endtask

  initial begin
    int d;
    int mode;
    int at;
    logic [15:0] in;
    start_d  = '0;
    abort_d  = '0;
    rstn_d   = '0;
    min_d    = '0;
    model[0] = 16'h0000;
    model[1] = 16'h0000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_data", 32'(data_w[i]), 32'd0);
      chk("rst_sel", 32'(sel_w[i]), 32'd0);
      chk("rst_busy", 32'(busy_w[i]), 32'd0);
      chk("rst_done", 32'(done_w[i]), 32'd0);
    end

    // abort at sel==5 on an all-ones input: channels 0..4 only
    run_scan(0, 16'hFFFF, 1, 11);
    chk("abort_low5", 32'(data_w[0]), 32'h001F);
    run_scan(0, 16'h5555, 0, 0);
    run_scan(0, 16'($urandom), 3, 7);
    run_scan(0, 16'h5555, 0, 0);
    // reset pulse while sel==9
    run_scan(0, 16'($urandom), 2, 19);
    // first start on the first edge out of reset
    run_scan(1, 16'h8001, 0, 0);
    idle_abort(0);
    idle_abort(1);

    for (int n = 0; n < 14; n++) begin
      d    = int'($urandom_range(0, 1));
      in   = 16'($urandom);
      mode = int'($urandom_range(0, 3));
      if (mode == 2) mode = 0;
      at   = (mode == 1) ? int'($urandom_range(1, 16 * settle(d)))
                         : int'($urandom_range(0, 16 * settle(d) - 1));
      run_scan(d, in, mode, at);
    end

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles `sel` is held per channel before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request one full 16-channel scan.
REQ-005 SHALL have port abort  input  1  cancel a scan in progress.
REQ-006 SHALL have port mux_out  input  1  output of the downstream 16:1 mux.
REQ-007 SHALL have port sel  output  4  channel select driven into the 16:1 mux.
REQ-008 SHALL have port data  output  16  captured channel values; data[k] is the sample taken while sel==k.
REQ-009 SHALL have port busy  output  1  high while a scan is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse when a scan completes.

Function
REQ-011 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-012 IDLE with start=1 and abort=0: next cycle SCAN, sel=0, settle counter=0, busy=1.
REQ-013 SCAN, counter<SETTLE-1: counter increments; sel held.
REQ-014 SCAN, counter==SETTLE-1: data[sel] <= mux_out at that edge; counter<=0.
REQ-015 After that sample: if sel!=15, sel increments; if sel==15, next state is DONE.
REQ-016 Scan length: exactly 16*SETTLE cycles in SCAN; done is high on cycle 16*SETTLE+1 after the start edge.
REQ-017 DONE lasts one cycle: done=1, busy=0, then IDLE.
REQ-018 sel SHALL be 0 in IDLE and DONE, and SHALL change only at channel boundaries, never mid-settle.
REQ-019 start while in SCAN or DONE SHALL be ignored, with no queuing.
REQ-020 abort=1 in SCAN: next cycle IDLE, sel=0, busy=0, no done pulse; bits already captured are kept, other bits unchanged.
REQ-021 abort and start together in IDLE: abort wins; the FSM stays in IDLE.
REQ-022 data SHALL hold its value from the end of a scan until overwritten by the next scan.
REQ-023 Bits not yet reached in a new scan SHALL hold their previous values.
REQ-024 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-025 rst_n=0 at a clock edge: state=IDLE, sel=0, data=16'h0000, busy=0, done=0, counter=0.
REQ-026 Reset asserted mid-scan SHALL abort the scan identically to REQ-025, with no done pulse.
REQ-027 The first start is accepted on the first edge with rst_n=1.

Structure
REQ-028 Shared package SHALL hold:
- the state encoding (IDLE, SCAN, DONE; 2 bits);
- the constants NUM_CH=16 and SEL_W=4.
REQ-029 The settle counter MAY be a sub-module named settle_cnt: width 4, clear plus terminal-count output; all other logic stays in one module.
REQ-030 Top-level integration SHALL connect sel and mux_out to the existing 16:1 mux (built from two 8:1 muxes).

Verification
REQ-031 Bench SHALL instantiate mux_scan_ctrl with the existing 16:1 mux and cover each scenario below.
REQ-032 Mux in=16'h5555, SETTLE=2, pulse start:
- data==16'h5555;
- done pulses exactly at cycle 33 after the start edge;
- busy high for 32 cycles.
REQ-033 in=16'h8001, SETTLE=1:
- sel steps 0..15, one cycle each;
- data==16'h8001;
- done at cycle 17.
REQ-034 in=16'hFFFF, SETTLE=2; assert abort when sel==5:
- next cycle busy=0, sel=0, no done;
- data[4:0]==5'h1F, data[15:5]==0.
REQ-035 Pulse start again during SCAN (SETTLE=2):
- ignored;
- done timing unchanged.
REQ-036 rst_n=0 for 1 cycle when sel==9 after a prior scan left data==16'h5555:
- next cycle data==16'h0000, sel=0, busy=0, done=0.
